// File: rtl/secuenciador_suma16_pkg.sv
// Shared constants and types for the 16-bit sequencer driving a sumador4 nibble adder.
package secuenciador_suma16_pkg;

  localparam int unsigned NumNibbles = 4;
  localparam int unsigned WordWidth  = 16;
  localparam logic [1:0]  LastNibble = 2'(NumNibbles - 1);

  typedef enum logic [1:0] {
    ModoHold  = 2'b00,
    ModoAdd   = 2'b01,
    ModoSub   = 2'b10,
    ModoClear = 2'b11
  } modo_e;

  typedef enum logic [1:0] {
    StIdle,
    StClr,
    StOp,
    StFin
  } state_e;

  function automatic logic [3:0] nibble(input logic [WordWidth-1:0] w, input logic [1:0] idx);
    return w[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/secuenciador_suma16_if.sv
// Host request/result signals plus the sumador4 control link, grouped in one bundle.
interface secuenciador_suma16_if;
  import secuenciador_suma16_pkg::*;

  logic                 start;
  logic                 op;
  logic [WordWidth-1:0] x;
  logic [WordWidth-1:0] y;
  logic                 cin;
  logic [WordWidth-1:0] z;
  logic                 cout;
  logic                 busy;
  logic                 done;
  logic                 s_enb;
  logic [1:0]           s_modo;
  logic [3:0]           s_a;
  logic [3:0]           s_b;
  logic                 s_rci;
  logic [3:0]           s_q;
  logic                 s_rco;

  // Host plus adder side: drives requests and the adder's results.
  modport master (
    output start, op, x, y, cin, s_q, s_rco,
    input  z, cout, busy, done, s_enb, s_modo, s_a, s_b, s_rci
  );

  // The sequencer itself.
  modport slave (
    input  start, op, x, y, cin, s_q, s_rco,
    output z, cout, busy, done, s_enb, s_modo, s_a, s_b, s_rci
  );

endinterface

// File: rtl/secuenciador_suma16.sv
// Sequences one 16-bit add/subtract as a clear plus four chained nibble ops on a sumador4.
module secuenciador_suma16
  import secuenciador_suma16_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  secuenciador_suma16_if.slave bus
);

  state_e               state_q;
  logic [1:0]           cnt_q;
  logic [WordWidth-1:0] x_q;
  logic [WordWidth-1:0] y_q;
  logic                 sub_q;
  logic                 cin_q;
  logic [11:0]          acc_q;
  logic [WordWidth-1:0] z_q;
  logic                 cout_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 enb_q;
  modo_e                modo_q;
  logic [3:0]           a_q;
  logic [3:0]           b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sub_q   <= 1'b0;
      cin_q   <= 1'b0;
      acc_q   <= '0;
      z_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      enb_q   <= 1'b0;
      modo_q  <= ModoHold;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            x_q     <= bus.x;
            y_q     <= bus.y;
            sub_q   <= bus.op;
            cin_q   <= bus.cin;
            busy_q  <= 1'b1;
            enb_q   <= 1'b1;
            modo_q  <= ModoClear;
            state_q <= StClr;
          end
        end
        StClr: begin
          state_q <= StOp;
          cnt_q   <= '0;
          modo_q  <= sub_q ? ModoSub : ModoAdd;
          a_q     <= nibble(x_q, 2'd0);
          b_q     <= nibble(y_q, 2'd0);
        end
        StOp: begin
          // The adder output now holds the previous nibble's result.
          if (cnt_q != 2'd0) acc_q[{cnt_q - 2'd1, 2'b00} +: 4] <= bus.s_q;
          if (cnt_q == LastNibble) begin
            state_q <= StFin;
            cnt_q   <= '0;
            enb_q   <= 1'b0;
            modo_q  <= ModoHold;
          end else begin
            cnt_q <= cnt_q + 2'd1;
            a_q   <= nibble(x_q, cnt_q + 2'd1);
            b_q   <= nibble(y_q, cnt_q + 2'd1);
          end
        end
        StFin: begin
          z_q     <= {bus.s_q, acc_q};
          cout_q  <= bus.s_rco;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Carry/borrow ripples straight from the adder's registered RCO; no wait state needed.
  assign bus.s_rci  = (state_q == StOp) && ((cnt_q == 2'd0) ? cin_q : bus.s_rco);
  assign bus.s_enb  = enb_q;
  assign bus.s_modo = modo_q;
  assign bus.s_a    = a_q;
  assign bus.s_b    = b_q;
  assign bus.z      = z_q;
  assign bus.cout   = cout_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_secuenciador_suma16.sv
// Directed bench: sequencer plus a behavioural sumador4, hand-computed expected results.
module tb_secuenciador_suma16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  secuenciador_suma16_if bus ();

  secuenciador_suma16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sumador4: registered, no reset.
  logic [4:0] add_r;
  logic [4:0] sub_r;
  assign add_r = {1'b0, bus.s_a} + {1'b0, bus.s_b} + {4'b0, bus.s_rci};
  assign sub_r = {1'b0, bus.s_a} - {1'b0, bus.s_b} - {4'b0, bus.s_rci};

  always @(posedge clk) begin
    if (bus.s_enb) begin
      case (bus.s_modo)
        2'b01:   {bus.s_rco, bus.s_q} <= add_r;
        2'b10:   {bus.s_rco, bus.s_q} <= sub_r;
        2'b11:   {bus.s_rco, bus.s_q} <= 5'd0;
        default: ;
      endcase
    end
  end

  logic [1:0]  modo_seq [0:5];
  logic        rci_seq  [0:5];
  logic        busy0;
  int          lat;
  logic [15:0] res_z;
  logic        res_cout;
  logic [15:0] hold_z;
  logic        z_moved;

  // Drives one request from the current sample point and records what the sequencer does.
  task automatic run_op(input logic op_i, input logic [15:0] x_i, input logic [15:0] y_i,
                        input logic cin_i, input bit pulse_busy);
    bus.op    = op_i;
    bus.x     = x_i;
    bus.y     = y_i;
    bus.cin   = cin_i;
    bus.start = 1'b1;
    hold_z    = bus.z;
    z_moved   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x     = ~x_i;
    bus.y     = ~y_i;
    bus.cin   = ~cin_i;
    bus.op    = ~op_i;
    modo_seq[0] = bus.s_modo;
    rci_seq[0]  = bus.s_rci;
    busy0       = bus.busy;
    lat         = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (pulse_busy) bus.start = (n == 2);
      if (n <= 5) begin
        modo_seq[n] = bus.s_modo;
        rci_seq[n]  = bus.s_rci;
      end
      if (bus.busy && bus.z !== hold_z) z_moved = 1'b1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL done_timeout got no DONE within 20 cycles want DONE at 6");
    end
    res_z    = bus.z;
    res_cout = bus.cout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.z, bus.cout, bus.busy, bus.done, bus.s_enb, bus.s_modo, bus.s_a, bus.s_b,
         bus.s_rci} !== 32'd0) begin
      errors++;
      $display("FAIL reset_values got z=%h cout=%b busy=%b done=%b enb=%b modo=%b a=%h b=%h rci=%b want all 0",
               bus.z, bus.cout, bus.busy, bus.done, bus.s_enb, bus.s_modo, bus.s_a, bus.s_b,
               bus.s_rci);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_basic();
    logic [1:0] exp_modo [0:5];
    exp_modo = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    checks++;
    if ({res_cout, res_z} !== {1'b0, 16'h2233}) begin
      errors++;
      $display("FAIL add_basic got cout=%b z=%h want cout=0 z=2233", res_cout, res_z);
    end
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL add_latency got %0d want 6", lat);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (modo_seq[i] !== exp_modo[i]) begin
        errors++;
        $display("FAIL add_modo[%0d] got %b want %b", i, modo_seq[i], exp_modo[i]);
      end
    end
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %b want 1", busy0);
    end
  endtask

  task automatic test_add_carry();
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checks++;
    if ({res_cout, res_z} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL add_carry got cout=%b z=%h want cout=1 z=0000", res_cout, res_z);
    end
    checks++;
    if ({rci_seq[1], rci_seq[2], rci_seq[3], rci_seq[4]} !== 4'b0111) begin
      errors++;
      $display("FAIL add_carry_rci got %b%b%b%b want 0111",
               rci_seq[1], rci_seq[2], rci_seq[3], rci_seq[4]);
    end
  endtask

  task automatic test_sub();
    run_op(1'b1, 16'h0002, 16'h0006, 1'b0, 1'b0);
    checks++;
    if ({res_cout, res_z} !== {1'b1, 16'hFFFC}) begin
      errors++;
      $display("FAIL sub_borrow got cout=%b z=%h want cout=1 z=fffc", res_cout, res_z);
    end
    checks++;
    if ({modo_seq[0], modo_seq[1], modo_seq[4], modo_seq[5]} !== 8'b11_10_10_00) begin
      errors++;
      $display("FAIL sub_modo got %b %b %b %b want 11 10 10 00",
               modo_seq[0], modo_seq[1], modo_seq[4], modo_seq[5]);
    end
    run_op(1'b1, 16'h1000, 16'h0001, 1'b0, 1'b0);
    checks++;
    if ({res_cout, res_z} !== {1'b0, 16'h0FFF}) begin
      errors++;
      $display("FAIL sub_noborrow got cout=%b z=%h want cout=0 z=0fff", res_cout, res_z);
    end
  endtask

  task automatic test_back_to_back();
    int extra;
    run_op(1'b0, 16'h000F, 16'h0000, 1'b1, 1'b1);
    checks++;
    if ({res_cout, res_z} !== {1'b0, 16'h0010}) begin
      errors++;
      $display("FAIL add_cin got cout=%b z=%h want cout=0 z=0010", res_cout, res_z);
    end
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL start_while_busy_latency got %0d want 6", lat);
    end
    // Issued in the DONE cycle.
    run_op(1'b1, 16'h1000, 16'h0001, 1'b0, 1'b0);
    checks++;
    if (lat != 6 || {res_cout, res_z} !== {1'b0, 16'h0FFF}) begin
      errors++;
      $display("FAIL back_to_back got lat=%0d cout=%b z=%h want lat=6 cout=0 z=0fff",
               lat, res_cout, res_z);
    end
    checks++;
    if (z_moved !== 1'b0) begin
      errors++;
      $display("FAIL z_hold_while_busy got z changed want z held at 0010");
    end
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL spurious_done got %0d extra pulses want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    bus.op    = 1'b0;
    bus.x     = 16'h1111;
    bus.y     = 16'h2222;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.z, bus.cout, bus.busy, bus.done, bus.s_enb, bus.s_modo, bus.s_a, bus.s_b,
         bus.s_rci} !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got z=%h cout=%b busy=%b done=%b enb=%b modo=%b a=%h b=%h rci=%b want all 0",
               bus.z, bus.cout, bus.busy, bus.done, bus.s_enb, bus.s_modo, bus.s_a, bus.s_b,
               bus.s_rci);
    end
    dones = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_done got %0d pulses want 0", dones);
    end
    run_op(1'b0, 16'h0005, 16'h0003, 1'b0, 1'b0);
    checks++;
    if ({res_cout, res_z} !== {1'b0, 16'h0008} || lat != 6) begin
      errors++;
      $display("FAIL after_reset_add got lat=%0d cout=%b z=%h want lat=6 cout=0 z=0008",
               lat, res_cout, res_z);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    bus.cin   = 1'b0;
    test_reset();
    @(posedge clk);
    #1;
    test_add_basic();
    test_add_carry();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
